sync_tx_arbiter: RTL and testbench
==================================

Name: sync_tx_arbiter

Overview:
Transmit-side scheduler for the two-flop fast 4-phase synchronizer channel. It shares one sync instance between NREQ core-side requesters using round-robin arbitration. It latches the winner's word onto indata and runs the full 4-phase vi/snt handshake before granting the next transfer. It lives entirely in the clk_tx domain, between the core requesters and the sync block's vi/indata/snt pins.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, word width; equals DATA_MSB+1 of the sync channel
TMO_CYC, 64, handshake watchdog limit in clk_tx cycles (used only with SYNC_ARB_TIMEOUT_EN)

Ports:
clk_tx  input  1  transmit clock; the only clock of this block
reset  input  1  synchronous, active-high reset, sampled on rising clk_tx
req  input  NREQ  per-requester transfer request, level, held until gnt
req_data  input  NREQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W]
gnt  output  NREQ  one-hot, one-cycle pulse: word of requester i captured
done  output  1  one-cycle pulse: 4-phase handshake fully returned to zero
busy  output  1  high in any state other than IDLE
grant_id  output  clog2(NREQ)  index of the current or last winner
vi  output  1  valid-in to sync block, registered
indata  output  DATA_W  data to sync block, registered, stable while vi or snt high
snt  input  1  sent/acknowledge from sync block; internally double-flopped to snt_s
err  output  1  sticky handshake timeout flag

Behaviour:
- Reset values (all outputs registered): vi=0, indata=0, gnt=0, done=0, busy=0, grant_id=0, err=0, state=IDLE, rr pointer=0, snt_s pipeline=0, watchdog=0.
- Reset has priority over every transition. Asserting reset mid-handshake forces vi=0 on the next edge and abandons the transfer; no done pulse.
- snt path: 2-flop synchronizer; the FSM acts only on snt_s (2-cycle input latency).
- FSM states: IDLE, REQ, ACK.
  - IDLE: if any req bit is high, on the edge:
    - pick the winner by round-robin, searching from rr pointer upward and wrapping;
    - indata <= winner's word, vi <= 1, gnt[winner] <= 1 for one cycle, grant_id <= winner;
    - rr pointer <= (winner+1) mod NREQ; state <= REQ.
    - If no req is high, stay in IDLE and hold everything.
  - REQ: vi held at 1. When snt_s==1: vi <= 0, state <= ACK.
  - ACK: vi=0, indata held. When snt_s==0: done <= 1 for one cycle, state <= IDLE.
- Throughput: IDLE lasts a minimum of 1 cycle, so a request pending when done fires is granted on the next edge.
- Fairness: a requester holding req continuously is served within NREQ transfers.
- Request handling:
  - req bits are not sampled in REQ or ACK.
  - A requester must drop req in the cycle gnt is seen, or it is re-queued as a new request.
  - A req that falls before grant is simply never granted.
- indata changes only on the IDLE->REQ edge.
- Invariant: vi and snt_s never both rise in the same transfer phase. If snt_s==1 is seen in IDLE (stale acknowledge), no grant is issued until snt_s==0.

Optional Feature:
SYNC_ARB_TIMEOUT_EN.
- Defined: a watchdog counter is cleared on entry to REQ and on REQ->ACK, and increments each cycle in REQ or ACK.
  - Reaching TMO_CYC in REQ: vi <= 0, err <= 1, state <= ACK.
  - Reaching TMO_CYC in ACK: err <= 1, state <= IDLE, no done pulse.
  - err stays set until reset.
- Not defined: no counter is synthesized, err is tied to 0, and the FSM waits indefinitely on snt_s.

Test Plan:
- Single transfer: reset 3 cycles, req=4'b0001, req_data[7:0]=8'hFF -> gnt=4'b0001 one cycle; vi=1 and indata=8'hFF next edge; sync block returns snt; vi falls 2 cycles after snt rises; done pulses 2 cycles after snt falls; busy=0 after.
- Round-robin: req=4'b1111 held, words 8'h11/8'h22/8'h33/8'h44 -> indata sequence 11,22,33,44,11; grant_id 0,1,2,3,0; exactly one gnt per done.
- Wrap and skip: rr pointer=3 after one grant, req=4'b0101 -> next winner 0, then 2; requester 3 never granted.
- Reset mid-handshake: assert reset while in REQ with vi=1 -> vi=0, busy=0, grant_id=0 after one edge; no done; next req=4'b0010 is granted normally.
- Stale acknowledge: hold snt=1 in IDLE with req=4'b0001 -> no gnt until snt low for 2 cycles, then gnt issued.
- Timeout (SYNC_ARB_TIMEOUT_EN, TMO_CYC=16): tie snt=0 and issue one request -> vi falls and err=1 at cycle 16 after grant; block reaches IDLE; err stays 1 until reset; without the macro, vi stays 1 for 250 cycles and err=0.

Source files
------------

// File: rtl/sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sync_tx_arbiter
// Purpose  : Transmit-side scheduler for a two-flop 4-phase synchronizer
//            channel. Round-robin arbitrates NREQ requesters, latches the
//            winner's word onto indata and runs the full vi/snt 4-phase
//            handshake before the next grant. Single clock domain (clk_tx).
// Ports    : clk_tx    - transmit clock
//            reset     - synchronous active-high reset
//            req       - per-requester level request
//            req_data  - packed request words, requester i at [i*DATA_W +: DATA_W]
//            gnt       - one-hot, one-cycle grant pulse
//            done      - one-cycle pulse when the handshake returns to zero
//            busy      - high whenever the FSM is not idle
//            grant_id  - index of the current or last winner
//            vi        - valid-in to the sync block
//            indata    - data to the sync block
//            snt       - acknowledge from the sync block (asynchronous)
//            err       - sticky handshake timeout flag
// Options  : SYNC_ARB_TIMEOUT_EN - enables the TMO_CYC handshake watchdog;
//            when undefined err is tied low and the FSM waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module sync_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 64
) (
    input  logic                      clk_tx,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      vi,
    output logic [DATA_W-1:0]         indata,
    input  logic                      snt,
    output logic                      err
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Unsupported configurations stop elaboration instead of building silently.
    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 2) begin : g_param_check
        $error("sync_tx_arbiter: unsupported parameter value");
    end

    state_t              r_state, w_state;
    logic [ID_W-1:0]     r_rr, w_rr;
    logic                r_snt_m, r_snt_s;
    logic                r_vi, w_vi;
    logic [DATA_W-1:0]   r_indata, w_indata;
    logic [NREQ-1:0]     r_gnt, w_gnt;
    logic                r_done, w_done;
    logic                r_busy, w_busy;
    logic [ID_W-1:0]     r_grant_id, w_grant_id;
    logic                w_found;
    logic [ID_W-1:0]     w_win;

`ifdef SYNC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    logic [WD_W-1:0]     r_wd, w_wd;
    logic                r_err, w_err;
    logic                w_wd_hit;
    assign w_wd_hit = (r_wd == WD_W'(TMO_CYC - 1));
    assign err      = r_err;
`else
    assign err      = 1'b0;
`endif

    // Round-robin search: first active request at or above the pointer,
    // wrapping past NREQ-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(r_rr) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_rr       = r_rr;
        w_vi       = r_vi;
        w_indata   = r_indata;
        w_gnt      = '0;
        w_done     = 1'b0;
        w_grant_id = r_grant_id;
`ifdef SYNC_ARB_TIMEOUT_EN
        w_wd       = r_wd;
        w_err      = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                // A stale acknowledge must clear before a new transfer starts,
                // otherwise vi and snt_s would rise in the same phase.
                if (w_found && !r_snt_s) begin
                    w_indata     = req_data[int'(w_win)*DATA_W +: DATA_W];
                    w_vi         = 1'b1;
                    w_gnt[w_win] = 1'b1;
                    w_grant_id   = w_win;
                    w_rr         = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    w_state      = ST_REQ;
`ifdef SYNC_ARB_TIMEOUT_EN
                    w_wd         = '0;
`endif
                end
            end
            ST_REQ: begin
                if (r_snt_s) begin
                    w_vi    = 1'b0;
                    w_state = ST_ACK;
`ifdef SYNC_ARB_TIMEOUT_EN
                    w_wd    = '0;
                end else if (w_wd_hit) begin
                    w_vi    = 1'b0;
                    w_err   = 1'b1;
                    w_state = ST_ACK;
                    w_wd    = '0;
                end else begin
                    w_wd    = r_wd + 1'b1;
`endif
                end
            end
            ST_ACK: begin
                if (!r_snt_s) begin
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
`ifdef SYNC_ARB_TIMEOUT_EN
                end else if (w_wd_hit) begin
                    // Abandon the transfer without signalling completion.
                    w_err   = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_wd    = r_wd + 1'b1;
`endif
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_vi    = 1'b0;
            end
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk_tx) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr       <= '0;
            r_snt_m    <= 1'b0;
            r_snt_s    <= 1'b0;
            r_vi       <= 1'b0;
            r_indata   <= '0;
            r_gnt      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
`ifdef SYNC_ARB_TIMEOUT_EN
            r_wd       <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_rr       <= w_rr;
            r_snt_m    <= snt;
            r_snt_s    <= r_snt_m;
            r_vi       <= w_vi;
            r_indata   <= w_indata;
            r_gnt      <= w_gnt;
            r_done     <= w_done;
            r_busy     <= w_busy;
            r_grant_id <= w_grant_id;
`ifdef SYNC_ARB_TIMEOUT_EN
            r_wd       <= w_wd;
            r_err      <= w_err;
`endif
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign vi       = r_vi;
    assign indata   = r_indata;

endmodule
`default_nettype wire

// File: tb/tb_sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_tx_arbiter
// Purpose  : Self-checking bench for sync_tx_arbiter. A vector table drives
//            request patterns; expected winners are queued when a pattern is
//            driven and popped when the grant appears. The bench also plays
//            the sync block's snt side of the handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 16;
    localparam int NV      = 12;

    logic        clk_tx = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  req    = '0;
    logic [31:0] req_data = '0;
    logic        snt    = 1'b0;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        vi;
    logic [7:0]  indata;
    logic        err;

    sync_tx_arbiter #(
        .NREQ    (NREQ),
        .DATA_W  (DATA_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk_tx   (clk_tx),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id),
        .vi       (vi),
        .indata   (indata),
        .snt      (snt),
        .err      (err)
    );

    always #5 clk_tx = ~clk_tx;

    int n_vec = 0;
    int n_bad = 0;
    int n_gnt = 0;
    int n_done = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] word;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  req_after;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  word;
    } vec_t;
    vec_t tbl[NV];

    always @(negedge clk_tx) begin
        if (gnt != 4'b0) n_gnt++;
        if (done) n_done++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    // One complete transfer: wait for the grant, compare it against the
    // scoreboard, then play the sync block through both handshake phases.
    task automatic transfer(input logic [3:0] req_after);
        exp_t       e;
        int         n;
        logic [7:0] held;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        if (gnt == 4'b0) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_wait: no gnt within 20 cycles, expected one");
            req = 4'b0;
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("gnt", gnt, 32'(4'b1 << e.id));
        check("grant_id", grant_id, e.id);
        check("indata", indata, e.word);
        check("vi_rise", vi, 1);
        check("busy", busy, 1);
        req  = req_after;
        held = indata;
        tick();
        check("gnt_pulse", gnt, 0);
        snt = 1'b1;
        n = 0;
        while (vi && n < 10) begin
            tick();
            n++;
        end
        check_range("vi_fall_cycles", n, 2, 3);
        check("indata_hold", indata, held);
        snt = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check_range("done_cycles", n, 2, 3);
        check("busy_at_done", busy, 0);
        check("err_clear", err, 0);
    endtask

    initial begin
        int   n;
        logic seen;
        logic [31:0] d;
        d = {8'h44, 8'h33, 8'h22, 8'h11};

        // Pointer starts at 0; each row's winner follows from the pointer
        // left by the previous row.
        tbl[0]  = '{4'b0001, 4'b0000, {8'h44, 8'h33, 8'h22, 8'hFF}, 2'd0, 8'hFF};
        tbl[1]  = '{4'b1111, 4'b1111, d, 2'd1, 8'h22};
        tbl[2]  = '{4'b1111, 4'b1111, d, 2'd2, 8'h33};
        tbl[3]  = '{4'b1111, 4'b1111, d, 2'd3, 8'h44};
        tbl[4]  = '{4'b1111, 4'b1111, d, 2'd0, 8'h11};
        tbl[5]  = '{4'b1111, 4'b0000, d, 2'd1, 8'h22};
        tbl[6]  = '{4'b0100, 4'b0000, d, 2'd2, 8'h33};
        tbl[7]  = '{4'b0101, 4'b0100, d, 2'd0, 8'h11};
        tbl[8]  = '{4'b0100, 4'b0000, d, 2'd2, 8'h33};
        tbl[9]  = '{4'b1000, 4'b0000, d, 2'd3, 8'h44};
        tbl[10] = '{4'b0110, 4'b0100, d, 2'd1, 8'h22};
        tbl[11] = '{4'b0100, 4'b0000, d, 2'd2, 8'h33};

        reset = 1'b1;
        repeat (3) tick();
        check("rst_vi", vi, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_indata", indata, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            sb.push_back('{tbl[i].id, tbl[i].word});
            transfer(tbl[i].req_after);
        end
        tick();
        check("gnt_count", n_gnt, NV);
        check("done_count", n_done, NV);

        // Stale acknowledge: snt high in IDLE blocks the grant until it has
        // cleared through the synchronizer. Pointer is 3 here.
        req_data = d;
        snt = 1'b1;
        repeat (3) tick();
        req = 4'b0001;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (gnt != 4'b0) seen = 1'b1;
        end
        check("stale_ack_no_gnt", seen, 0);
        snt = 1'b0;
        tick();
        check("stale_ack_still_blocked", gnt, 0);
        sb.push_back('{2'd0, 8'h11});
        transfer(4'b0000);

        // Reset mid-handshake abandons the transfer.
        req = 4'b0010;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check("mid_rst_grant", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        check("mid_rst_vi_before", vi, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_vi", vi, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant_id", grant_id, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("mid_rst_no_done", seen, 0);
        req = 4'b0010;
        sb.push_back('{2'd1, 8'h22});
        transfer(4'b0000);

        // Sync block never answers.
        req = 4'b0001;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check("tmo_grant", gnt, 4'b0001);
        req = 4'b0000;
`ifdef SYNC_ARB_TIMEOUT_EN
        n = 0;
        while (vi && n < 300) begin
            tick();
            n++;
        end
        check("tmo_vi_fall_cycle", n, TMO_CYC);
        check("tmo_err", err, 1);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("tmo_idle", busy, 0);
        repeat (5) tick();
        check("tmo_err_sticky", err, 1);
        reset = 1'b1;
        tick();
        check("tmo_err_reset", err, 0);
        reset = 1'b0;
`else
        n = 0;
        while (vi && n < 250) begin
            tick();
            n++;
        end
        check("no_tmo_vi_held", n, 250);
        check("no_tmo_err", err, 0);
        check("no_tmo_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("no_tmo_reset_vi", vi, 0);
        reset = 1'b0;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
